// File: rtl/pacman_mover.sv
// Tile-stepping mover for a Pac-Man style maze: buffers the requested direction,
// asks the wall ROM about neighbouring tiles once per movement tick, and advances.
module pacman_mover #(
    parameter int GRID_W   = 28,
    parameter int GRID_H   = 31,
    parameter int MOVE_DIV = 2500000,
    parameter int START_X  = 13,
    parameter int START_Y  = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] direction,
    output logic [4:0] query_x,
    output logic [4:0] query_y,
    input  logic       wall_hit,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic [2:0] heading,
    output logic       moved,
    output logic       blocked
);

    localparam logic [2:0]  DIR_NONE  = 3'd0;
    localparam logic [2:0]  DIR_RIGHT = 3'd1;
    localparam logic [2:0]  DIR_DOWN  = 3'd4;
    localparam logic [4:0]  X_MAX     = 5'(GRID_W - 1);
    localparam logic [4:0]  Y_MAX     = 5'(GRID_H - 1);
    localparam logic [4:0]  X_START   = 5'(START_X);
    localparam logic [4:0]  Y_START   = 5'(START_Y);
    localparam logic [23:0] CNT_MAX   = 24'(MOVE_DIV - 1);

    typedef enum logic [2:0] {IDLE, Q_WANT, S_WANT, Q_HEAD, S_HEAD} state_t;

    state_t      state_reg, state_next;
    logic [23:0] cnt_reg, cnt_next;
    logic [2:0]  want_reg, want_next;
    logic [2:0]  heading_reg, heading_next;
    logic [2:0]  step_dir_reg, step_dir_next;
    logic [4:0]  pos_x_reg, pos_x_next;
    logic [4:0]  pos_y_reg, pos_y_next;
    logic [4:0]  query_x_reg, query_x_next;
    logic [4:0]  query_y_reg, query_y_next;
    logic        oob_reg, oob_next;
    logic        moved_reg, moved_next;
    logic        blocked_reg, blocked_next;

    logic        tick;
    logic        hit;

    // Neighbour table indexed by direction code; unused codes map to the current tile.
    logic [4:0]  nbr_x   [0:7];
    logic [4:0]  nbr_y   [0:7];
    logic        nbr_oob [0:7];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nbr
            if (gi == 1) begin : g_right
                assign nbr_x[gi]   = (pos_x_reg == X_MAX) ? 5'd0 : pos_x_reg + 5'd1;
                assign nbr_y[gi]   = pos_y_reg;
                assign nbr_oob[gi] = 1'b0;
            end else if (gi == 2) begin : g_left
                assign nbr_x[gi]   = (pos_x_reg == 5'd0) ? X_MAX : pos_x_reg - 5'd1;
                assign nbr_y[gi]   = pos_y_reg;
                assign nbr_oob[gi] = 1'b0;
            end else if (gi == 3) begin : g_up
                // Off the top edge: keep the query on the current tile and force a wall.
                assign nbr_x[gi]   = pos_x_reg;
                assign nbr_y[gi]   = (pos_y_reg == 5'd0) ? pos_y_reg : pos_y_reg - 5'd1;
                assign nbr_oob[gi] = (pos_y_reg == 5'd0);
            end else if (gi == 4) begin : g_down
                assign nbr_x[gi]   = pos_x_reg;
                assign nbr_y[gi]   = (pos_y_reg == Y_MAX) ? pos_y_reg : pos_y_reg + 5'd1;
                assign nbr_oob[gi] = (pos_y_reg == Y_MAX);
            end else begin : g_self
                assign nbr_x[gi]   = pos_x_reg;
                assign nbr_y[gi]   = pos_y_reg;
                assign nbr_oob[gi] = 1'b0;
            end
        end
    endgenerate

    assign tick = (cnt_reg == CNT_MAX);
    assign hit  = wall_hit | oob_reg;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (tick && want_reg != DIR_NONE) begin
                    state_next = Q_WANT;
                end else if (tick && heading_reg != DIR_NONE) begin
                    state_next = Q_HEAD;
                end
            end
            Q_WANT: state_next = S_WANT;
            S_WANT: begin
                if (hit && heading_reg != DIR_NONE) begin
                    state_next = Q_HEAD;
                end else begin
                    state_next = IDLE;
                end
            end
            Q_HEAD: state_next = S_HEAD;
            S_HEAD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and pulse outputs
    always_comb begin
        cnt_next      = tick ? 24'd0 : cnt_reg + 24'd1;
        want_next     = want_reg;
        heading_next  = heading_reg;
        step_dir_next = step_dir_reg;
        pos_x_next    = pos_x_reg;
        pos_y_next    = pos_y_reg;
        query_x_next  = query_x_reg;
        query_y_next  = query_y_reg;
        oob_next      = oob_reg;
        moved_next    = 1'b0;
        blocked_next  = 1'b0;

        if (direction >= DIR_RIGHT && direction <= DIR_DOWN) begin
            want_next = direction;
        end

        case (state_reg)
            IDLE: begin
                if (tick && want_reg != DIR_NONE) begin
                    query_x_next  = nbr_x[want_reg];
                    query_y_next  = nbr_y[want_reg];
                    oob_next      = nbr_oob[want_reg];
                    step_dir_next = want_reg;
                end else if (tick && heading_reg != DIR_NONE) begin
                    query_x_next  = nbr_x[heading_reg];
                    query_y_next  = nbr_y[heading_reg];
                    oob_next      = nbr_oob[heading_reg];
                    step_dir_next = heading_reg;
                end
            end
            S_WANT: begin
                // The direction latched at query time becomes the heading, so a
                // want change during the lookup cannot mislabel the move.
                if (!hit) begin
                    pos_x_next   = query_x_reg;
                    pos_y_next   = query_y_reg;
                    heading_next = step_dir_reg;
                    moved_next   = 1'b1;
                end else if (heading_reg != DIR_NONE) begin
                    query_x_next  = nbr_x[heading_reg];
                    query_y_next  = nbr_y[heading_reg];
                    oob_next      = nbr_oob[heading_reg];
                    step_dir_next = heading_reg;
                end
            end
            S_HEAD: begin
                if (!hit) begin
                    pos_x_next = query_x_reg;
                    pos_y_next = query_y_reg;
                    moved_next = 1'b1;
                end else begin
                    heading_next = DIR_NONE;
                    blocked_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg      <= 24'd0;
            want_reg     <= DIR_NONE;
            heading_reg  <= DIR_NONE;
            step_dir_reg <= DIR_NONE;
            pos_x_reg    <= X_START;
            pos_y_reg    <= Y_START;
            query_x_reg  <= X_START;
            query_y_reg  <= Y_START;
            oob_reg      <= 1'b0;
            moved_reg    <= 1'b0;
            blocked_reg  <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            want_reg     <= want_next;
            heading_reg  <= heading_next;
            step_dir_reg <= step_dir_next;
            pos_x_reg    <= pos_x_next;
            pos_y_reg    <= pos_y_next;
            query_x_reg  <= query_x_next;
            query_y_reg  <= query_y_next;
            oob_reg      <= oob_next;
            moved_reg    <= moved_next;
            blocked_reg  <= blocked_next;
        end
    end

    assign query_x = query_x_reg;
    assign query_y = query_y_reg;
    assign pos_x   = pos_x_reg;
    assign pos_y   = pos_y_reg;
    assign heading = heading_reg;
    assign moved   = moved_reg;
    assign blocked = blocked_reg;

endmodule

// File: doc/pacman_mover.md
PACMAN_MOVER -- requirements
Module: pacman_mover

Interface
REQ-001 Parameter GRID_W, default 28, maze width in tiles.
REQ-002 Parameter GRID_H, default 31, maze height in tiles.
REQ-003 Parameter MOVE_DIV, default 2500000, clock cycles per movement step; legal range 8 to 2^24-1.
REQ-004 Parameters START_X, default 13, and START_Y, default 23, give the reset tile.
REQ-005 Port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset; when 0 at a clk edge, all state is reset.
REQ-007 Port direction  in  3  key-decoder code: 0 stationary, 1 right, 2 left, 3 up, 4 down; 5-7 illegal.
REQ-008 Port query_x  out  5  registered tile column presented to the maze wall ROM.
REQ-009 Port query_y  out  5  registered tile row presented to the maze wall ROM.
REQ-010 Port wall_hit  in  1  ROM answer, 1 = wall; valid exactly one cycle after query_x/query_y.
REQ-011 Port pos_x  out  5  current tile column.
REQ-012 Port pos_y  out  5  current tile row.
REQ-013 Port heading  out  3  current motion direction, same encoding as direction.
REQ-014 Port moved  out  1  one-cycle pulse, position changed.
REQ-015 Port blocked  out  1  one-cycle pulse, motion stopped by a wall.

Function
REQ-016 Requested-direction buffer want: at every clk edge, a direction of 1-4 loads want; 0 and 5-7 leave want unchanged.
REQ-017 Tick counter: counts 0..MOVE_DIV-1 and wraps to 0; tick is true in the cycle the count equals MOVE_DIV-1.
REQ-018 FSM states: IDLE, Q_WANT, S_WANT, Q_HEAD, S_HEAD.
REQ-019 IDLE on tick, with want != 0: load query with the neighbour of pos in want; go to Q_WANT.
REQ-020 IDLE on tick, with want = 0 and heading != 0: load query with the neighbour in heading; go to Q_HEAD.
REQ-021 IDLE on tick, with want = 0 and heading = 0: remain in IDLE.
REQ-022 Q_WANT and Q_HEAD hold the query for one cycle, then advance to S_WANT and S_HEAD respectively.
REQ-023 S_WANT, wall_hit = 0: pos <= query, heading <= want, moved = 1 next cycle; go to IDLE.
REQ-024 S_WANT, wall_hit = 1 and heading != 0: load the heading neighbour into query; go to Q_HEAD.
REQ-025 S_WANT, wall_hit = 1 and heading = 0: go to IDLE; no pulse.
REQ-026 S_HEAD, wall_hit = 0: pos <= query, moved = 1 next cycle; go to IDLE.
REQ-027 S_HEAD, wall_hit = 1: heading <= 0, blocked = 1 next cycle; go to IDLE.
REQ-028 Neighbour arithmetic, horizontal: x-1 from 0 wraps to GRID_W-1; x+1 from GRID_W-1 wraps to 0 (tunnel).
REQ-029 Neighbour arithmetic, vertical: no wrap; up from row 0 or down from row GRID_H-1 is treated as wall_hit = 1 without using the ROM answer.
REQ-030 A tick arriving outside IDLE is dropped; the counter keeps running.
REQ-031 Step latency: the first move is taken at tick + 3 edges (S_WANT); a fallback move is taken at tick + 5 edges (S_HEAD).
REQ-032 moved and blocked are never both 1; each pulse is exactly one cycle long.
REQ-033 Reversal (want opposite heading) is legal and takes effect on the next tick if the target tile is clear.

Reset
REQ-034 reset = 0 at an edge: pos = (START_X, START_Y), heading = 0, want = 0, counter = 0, FSM = IDLE, query = (START_X, START_Y), moved = 0, blocked = 0.
REQ-035 Reset asserted mid-sequence (Q_*/S_* states) aborts the step; the pending ROM answer is ignored; no pulse is issued.
REQ-036 Outputs hold their reset values from the first edge after release until the first tick.

Verification
REQ-037 MOVE_DIV = 8, open maze, direction = 1 for one cycle then 0 -> pos_x 13->14->15 on successive ticks; moved pulses each step; heading = 1.
REQ-038 Heading = 1 at (27,14), open maze -> next step pos_x = 0, moved = 1; heading = 2 at x = 0 -> pos_x = 27.
REQ-039 Heading = 1, want = 3, wall above, right clear -> ROM queried twice; pos_x + 1, heading stays 1, moved = 1.
REQ-040 Heading = 1, walls right and above -> blocked = 1, heading = 0, pos unchanged; later ticks make no query change.
REQ-041 pos_y = 0, want = 3, heading = 0, ROM wall_hit forced 0 -> no move, no pulse, FSM returns to IDLE.
REQ-042 reset pulsed low in S_WANT with wall_hit = 0 -> pos = (13,23), heading = 0, no moved pulse; direction = 5 afterwards leaves want = 0.
